// File: rtl/regfile_gen.sv
// ---------------------------------------------------------------------------
// regfile_gen
//
// Three-port register file for the single-cycle MIPS datapath: two
// combinational read ports and one synchronous write port. The storage is
// zeroed by a sequential clear engine after reset or on request, during which
// `busy` is high, reads return 0 and writes are dropped.
//
// Compile-time option:
//   REGFILE_BYPASS_EN  - when defined, a read of the address being written in
//                        the same cycle (IDLE, we3=1) returns wd3 directly.
//
// Parameters:
//   WIDTH     data width in bits
//   AW        address width, DEPTH = 2**AW
//   ZERO_REG  1: register 0 reads as 0 and is never written
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-high reset (starts a full clear)
//   we3         write enable
//   wa3, wd3    write address / data
//   ra1, ra2    read addresses
//   disableRA1  forces rd1 to 0
//   clr_start   single-cycle request to start a full clear (ignored if busy)
//   rd1, rd2    combinational read data
//   busy        high while the clear engine runs
// ---------------------------------------------------------------------------
module regfile_gen #(
    parameter int WIDTH    = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we3,
    input  logic [AW-1:0]    wa3,
    input  logic [WIDTH-1:0] wd3,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    input  logic             disableRA1,
    input  logic             clr_start,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    output logic             busy
);

    localparam int            DEPTH    = 1 << AW;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t        state_reg, state_next;
    logic [AW-1:0] ptr_reg, ptr_next;

    // Storage is deliberately left out of the reset so it maps to
    // distributed RAM; the clear engine takes care of initialisation.
    logic [WIDTH-1:0] rf [DEPTH];

    logic             arr_we;
    logic [AW-1:0]    arr_addr;
    logic [WIDTH-1:0] arr_data;
    logic             wa3_zero;

    assign wa3_zero = (ZERO_REG != 0) && (wa3 == '0);

    // ---------------------------------------------------------------
    // Control state
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= CLEAR;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
        end
    end

    // Next state plus the single array write port, shared between the clear
    // engine and the datapath write.
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        arr_we     = 1'b0;
        arr_addr   = wa3;
        arr_data   = wd3;
        case (state_reg)
            IDLE: begin
                // A write on the clr_start edge is still accepted; the clear
                // wipes it later when the pointer reaches that register.
                arr_we = we3 && !wa3_zero;
                if (clr_start) begin
                    state_next = CLEAR;
                    ptr_next   = '0;
                end
            end
            CLEAR: begin
                arr_we   = 1'b1;
                arr_addr = ptr_reg;
                arr_data = '0;
                ptr_next = ptr_reg + PTR_ONE;  // wraps to 0 after the last entry
                if (ptr_reg == PTR_LAST) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = CLEAR;
                ptr_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (arr_we) begin
            rf[arr_addr] <= arr_data;
        end
    end

    assign busy = (state_reg == CLEAR);

    // ---------------------------------------------------------------
    // Read ports, one generated instance per port
    // ---------------------------------------------------------------
    logic [AW-1:0]    ra      [2];
    logic [WIDTH-1:0] rd      [2];
    logic             rd_kill [2];

    assign ra[0]      = ra1;
    assign ra[1]      = ra2;
    assign rd_kill[0] = disableRA1;
    assign rd_kill[1] = 1'b0;
    assign rd1        = rd[0];
    assign rd2        = rd[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_read
            logic hard_zero;
            assign hard_zero = (ZERO_REG != 0) && (ra[gi] == '0);

            always_comb begin
                rd[gi] = rf[ra[gi]];
`ifdef REGFILE_BYPASS_EN
                if (we3 && (state_reg == IDLE) && (ra[gi] == wa3) && !wa3_zero) begin
                    rd[gi] = wd3;
                end
`endif
                if (busy || rd_kill[gi] || hard_zero) begin
                    rd[gi] = '0;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_regfile_gen.sv
// ---------------------------------------------------------------------------
// tb_regfile_gen
//
// Drives two instances (ZERO_REG=1 and ZERO_REG=0) with the same directed
// stimulus. A behavioural model (array contents + remaining clear edges)
// predicts rd1/rd2/busy and is compared every negative clock edge; directed
// literal checks pin both the DUT and the model at key points.
// ---------------------------------------------------------------------------
module tb_regfile_gen;

    localparam int W     = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk        = 1'b0;
    logic          reset      = 1'b0;
    logic          we3        = 1'b0;
    logic          disableRA1 = 1'b0;
    logic          clr_start  = 1'b0;
    logic [AW-1:0] wa3        = '0;
    logic [AW-1:0] ra1        = '0;
    logic [AW-1:0] ra2        = '0;
    logic [W-1:0]  wd3        = '0;

    logic [W-1:0]  rd1_z, rd2_z, rd1_n, rd2_n;
    logic          busy_z, busy_n;

    int tests    = 0;
    int fails    = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    regfile_gen #(.WIDTH(W), .AW(AW), .ZERO_REG(1)) dut_z (
        .clk(clk), .reset(reset), .we3(we3), .wa3(wa3), .wd3(wd3),
        .ra1(ra1), .ra2(ra2), .disableRA1(disableRA1), .clr_start(clr_start),
        .rd1(rd1_z), .rd2(rd2_z), .busy(busy_z)
    );

    regfile_gen #(.WIDTH(W), .AW(AW), .ZERO_REG(0)) dut_n (
        .clk(clk), .reset(reset), .we3(we3), .wa3(wa3), .wd3(wd3),
        .ra1(ra1), .ra2(ra2), .disableRA1(disableRA1), .clr_start(clr_start),
        .rd1(rd1_n), .rd2(rd2_n), .busy(busy_n)
    );

    // ---------------------------------------------------------------
    // Model: index 0 = ZERO_REG=1 instance, index 1 = ZERO_REG=0 instance.
    // busy_left counts clear edges still to come; when it hits zero the
    // whole file is zero (nothing is observable mid-clear).
    // ---------------------------------------------------------------
    logic [W-1:0] mem [2][DEPTH];
    int busy_left = DEPTH;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_left = DEPTH;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin
                for (int k = 0; k < 2; k++)
                    for (int i = 0; i < DEPTH; i++)
                        mem[k][i] = '0;
            end
        end else begin
            for (int k = 0; k < 2; k++)
                if (we3 && !(k == 0 && wa3 == '0))
                    mem[k][wa3] = wd3;
            if (clr_start)
                busy_left = DEPTH;
        end
    end

    function automatic logic [W-1:0] exp_rd(int k, logic [AW-1:0] ra, logic kill);
        if (busy_left > 0 || kill) return '0;
        if (k == 0 && ra == '0) return '0;
        if (BYP && we3 && ra == wa3) return wd3;
        return mem[k][ra];
    endfunction

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("busy_z", W'(busy_z), W'(busy_left > 0));
            chk("busy_n", W'(busy_n), W'(busy_left > 0));
            chk("rd1_z", rd1_z, exp_rd(0, ra1, disableRA1));
            chk("rd2_z", rd2_z, exp_rd(0, ra2, 1'b0));
            chk("rd1_n", rd1_n, exp_rd(1, ra1, disableRA1));
            chk("rd2_n", rd2_n, exp_rd(1, ra2, 1'b0));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy_z && n < 100) begin
            step();
            n++;
        end
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [W-1:0] d);
        we3 = 1'b1; wa3 = a; wd3 = d;
        step();
        we3 = 1'b0;
    endtask

    int n;

    initial begin
        // Reset and initial clear
        #2 reset = 1'b1;
        check_en = 1'b1;
        step();
        step();
        reset = 1'b0;
        count_busy(n);
        chk("reset_clear_edges", W'(n), 32);
        $display("[TB] reset clear took %0d edges", n);

        // First write right after busy falls
        write(5, 32'hDEADBEEF);
        ra1 = 5;
        mid();
        chk("rd1_r5", rd1_z, 32'hDEADBEEF);
        chk("model_r5", mem[0][5], 32'hDEADBEEF);
        for (int a = 0; a < DEPTH; a++) begin
            ra2 = AW'(a);
            mid();
            chk("rd2_sweep", rd2_z, (a == 5) ? 32'hDEADBEEF : 32'h0);
        end
        $display("[TB] write r5=deadbeef, sweep done");

        // Register 0 handling
        write(0, 32'h12345678);
        ra1 = 0; ra2 = 0;
        mid();
        chk("zero_rd1_z", rd1_z, 32'h0);
        chk("zero_rd2_z", rd2_z, 32'h0);
        chk("zero_rd1_n", rd1_n, 32'h12345678);
        chk("zero_rd2_n", rd2_n, 32'h12345678);
        $display("[TB] r0 write: zr=%h nz=%h", rd1_z, rd1_n);

        // disableRA1 with identical read addresses
        write(7, 32'hA5A5A5A5);
        ra1 = 7; ra2 = 7; disableRA1 = 1'b1;
        mid();
        chk("disable_rd1", rd1_z, 32'h0);
        chk("disable_rd2", rd2_z, 32'hA5A5A5A5);
        disableRA1 = 1'b0;
        mid();
        chk("same_addr_rd1", rd1_z, 32'hA5A5A5A5);
        $display("[TB] disableRA1 rd1=%h rd2=%h", rd1_z, rd2_z);

        // Same-cycle write/read of r9
        write(9, 32'h11);
        we3 = 1'b1; wa3 = 9; wd3 = 32'h55; ra2 = 9;
        mid();
        chk("bypass_before_edge", rd2_z, BYP ? 32'h55 : 32'h11);
        step();
        we3 = 1'b0;
        chk("bypass_after_edge", rd2_z, 32'h55);
        $display("[TB] r9 same-cycle read bypass=%0d", BYP);

        // Fill r1..r30, then write r31 on the clr_start edge
        for (int i = 1; i < 31; i++) write(AW'(i), W'(i));
        ra1 = 17; ra2 = 30;
        mid();
        chk("fill_r17", rd1_z, 32'd17);
        chk("fill_r30", rd2_n, 32'd30);
        we3 = 1'b1; wa3 = 31; wd3 = 32'd31; clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        wa3 = 3; wd3 = 32'hFF;       // held write during clear must be dropped
        chk("clr_busy_rise", W'(busy_z), 32'h1);
        count_busy(n);
        we3 = 1'b0;
        chk("clr_edges", W'(n), 32);
        for (int a = 0; a < DEPTH; a++) begin
            ra1 = AW'(a); ra2 = AW'(a);
            mid();
            chk("post_clear_rd1_n", rd1_n, 32'h0);
            chk("post_clear_rd2_z", rd2_z, 32'h0);
        end
        $display("[TB] clr_start clear took %0d edges, file zero", n);

        // Reset in the middle of a clear
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        repeat (10) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        count_busy(n);
        chk("midclear_reset_edges", W'(n), 32);
        chk("idle_after_reset", W'(busy_n), 32'h0);
        write(12, 32'h77);
        ra1 = 12;
        mid();
        chk("idle_write_r12", rd1_z, 32'h77);
        $display("[TB] mid-clear reset took %0d edges, r12=%h", n, rd1_z);

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
